// File: rtl/pass_disp_pkg.sv
// Purpose: shared segment codes, hex glyph table and counter sizing for the password display.
// Latency: n/a (constants and a sizing helper only).
// Backpressure: n/a.
package pass_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Scan divider width, $clog2(SCAN_DIV), floored at one bit.
    function automatic int cnt_w(input int scan_div);
        return (scan_div > 2) ? $clog2(scan_div) : 1;
    endfunction

endpackage

// File: rtl/pass_display_scanner_hex_to_seg7.sv
// Purpose: nibble to active-low 7-segment glyph.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg7
    import pass_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/pass_display_scanner.sv
// Purpose: scanned common-anode display of a captured password; PASS_REVEAL_LAST_EN briefly unmasks the newest digit.
// Latency: one registered cycle from idx/captured data to an/seg.
// Backpressure: none; load is a single-cycle strobe that is always accepted.
module pass_display_scanner
    import pass_disp_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 100000,
    parameter int REVEAL_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   password_in,
    input  logic [DIGITS-1:0]     digit_valid,
    input  logic                  load,
    input  logic                  mask_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = cnt_w(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    generate
        if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 2 || REVEAL_CYCLES < 1) begin : g_bad_param
            $error("pass_display_scanner: illegal parameter set");
        end
    endgenerate

    logic [4*DIGITS-1:0] pw_q;
    logic [DIGITS-1:0]   val_q;
    logic [CNT_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          cur_nib;
    logic                cur_val;
    logic [6:0]          hex_seg;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;
    logic                reveal;

    assign cur_nib = pw_q[{idx, 2'b00} +: 4];
    assign cur_val = val_q[idx];
    assign an_nxt  = ~(DIGITS'(1) << idx);

    hex_to_seg7 u_hex (
        .nib (cur_nib),
        .seg (hex_seg)
    );

`ifdef PASS_REVEAL_LAST_EN
    localparam int REV_W = $clog2(REVEAL_CYCLES + 1);

    logic [REV_W-1:0]  rev_cnt;
    logic [IDX_W-1:0]  rev_idx;
    logic [DIGITS-1:0] new_bits;
    logic [IDX_W-1:0]  new_top;

    assign new_bits = digit_valid & ~val_q;

    always_comb begin
        new_top = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (new_bits[i]) new_top = IDX_W'(i);
        end
    end

    // A fresh digit restarts the window; a load dropping the revealed digit ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_cnt <= '0;
            rev_idx <= '0;
        end else if (load && (|new_bits)) begin
            rev_cnt <= REV_W'(REVEAL_CYCLES);
            rev_idx <= new_top;
        end else if (load && !digit_valid[rev_idx]) begin
            rev_cnt <= '0;
        end else if (rev_cnt != '0) begin
            rev_cnt <= rev_cnt - REV_W'(1);
        end
    end

    assign reveal = (rev_cnt != '0) && (rev_idx == idx);
`else
    assign reveal = 1'b0;
`endif

    always_comb begin
        seg_nxt = hex_seg;
        if (!cur_val)
            seg_nxt = SEG_BLANK;
        else if (mask_en && !reveal)
            seg_nxt = SEG_DASH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pw_q    <= '0;
            val_q   <= '0;
            div_cnt <= '0;
            idx     <= '0;
            an      <= '1;
            seg     <= SEG_BLANK;
        end else begin
            if (load) begin
                pw_q  <= password_in;
                val_q <= digit_valid;
            end
            // Explicit wrap keeps non-power-of-two digit counts on legal indices.
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_pass_display_scanner.sv
// Purpose: self-checking bench for pass_display_scanner (4-digit and 3-digit instances).
// Latency: expects outputs one edge after capture/index change.
// Backpressure: n/a.
module tb_pass_display_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] password_in;
    logic [3:0]  digit_valid;
    logic        load;
    logic        mask_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [11:0] pw3  = 12'h000;
    logic [2:0]  val3 = 3'b000;
    logic [2:0]  an3;
    logic [6:0]  seg3;
    logic        dp3;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t       sb_q[$];
    logic [2:0] q3[$];
    exp_t       e;
    logic [2:0] e3;
    logic [3:0] prev_an  = 4'hF;
    int         run      = 0;
    logic [2:0] prev_an3 = 3'h7;
    int         run3     = 0;

    always #5 clk = ~clk;

    pass_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .REVEAL_CYCLES(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .password_in (password_in),
        .digit_valid (digit_valid),
        .load        (load),
        .mask_en     (mask_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    pass_display_scanner #(.DIGITS(3), .SCAN_DIV(2), .REVEAL_CYCLES(10)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .password_in (pw3),
        .digit_valid (val3),
        .load        (1'b0),
        .mask_en     (1'b0),
        .an          (an3),
        .seg         (seg3),
        .dp          (dp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        sb_q.push_back('{an: 4'hE, seg: s0});
        sb_q.push_back('{an: 4'hD, seg: s1});
        sb_q.push_back('{an: 4'hB, seg: s2});
        sb_q.push_back('{an: 4'h7, seg: s3});
    endtask

    // Dwell per digit is checked on every anode change; the scoreboard pops on each digit's second cycle.
    always @(negedge clk) begin
        if (an !== prev_an) begin
            if (prev_an !== 4'hF && an !== 4'hF)
                check("dwell4", run, 4);
            run     = 1;
            prev_an = an;
        end else begin
            run++;
        end
        if (run == 2 && an !== 4'hF && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("scan_an", an, e.an);
            check("scan_seg", seg, e.seg);
        end
    end

    always @(negedge clk) begin
        if (an3 !== prev_an3) begin
            if (rst_n === 1'b1) begin
                if (prev_an3 !== 3'h7)
                    check("dwell3", run3, 2);
                if (q3.size() > 0) begin
                    e3 = q3.pop_front();
                    check("an3_seq", an3, e3);
                end
            end
            run3     = 1;
            prev_an3 = an3;
        end else begin
            run3++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        password_in = 16'h0000;
        digit_valid = 4'h0;
        load        = 1'b0;
        mask_en     = 1'b0;
        tick(3);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_an3", an3, 3'h7);

        // Hex display of 1A3F, captured on the first edge after release.
        password_in = 16'h1A3F;
        digit_valid = 4'hF;
        load        = 1'b1;
        push_frame(7'h0E, 7'h30, 7'h08, 7'h79);
        for (int i = 0; i < 2; i++) begin
            q3.push_back(3'h6);
            q3.push_back(3'h5);
            q3.push_back(3'h3);
        end
        rst_n = 1'b1;
        tick(1);
        load = 1'b0;
        check("first_anode", an, 4'hE);
        tick(15);

        // Two entered digits, masked.
        digit_valid = 4'b0011;
        mask_en     = 1'b1;
        load        = 1'b1;
        push_frame(7'h3F, 7'h3F, 7'h7F, 7'h7F);
        tick(1);
        load = 1'b0;
        tick(15);

        // Unmask part-way through digit 0.
        push_frame(7'h3F, 7'h30, 7'h7F, 7'h7F);
        tick(2);
        mask_en = 1'b0;
        tick(1);
        check("mask_off_an", an, 4'hE);
        check("mask_off_seg", seg, 7'h0E);
        tick(12);

        // Load coincident with the frame wrap edge.
        password_in = 16'h5C8B;
        digit_valid = 4'hF;
        load        = 1'b1;
        push_frame(7'h03, 7'h00, 7'h46, 7'h12);
        tick(1);
        load = 1'b0;
        check("pre_wrap_an", an, 4'h7);
        tick(1);
        check("wrap_load_an", an, 4'hE);
        check("wrap_load_seg", seg, 7'h03);
        tick(14);

        // Mid-frame reset must blank before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_an3", an3, 3'h7);
        check("sb_empty", sb_q.size(), 0);
        check("sb3_empty", q3.size(), 0);
        tick(2);

`ifdef PASS_REVEAL_LAST_EN
        password_in = 16'h0072;
        digit_valid = 4'b0001;
        mask_en     = 1'b1;
        load        = 1'b1;
        rst_n       = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        check("reveal_first_seg", seg, 7'h24);
        tick(9);
        digit_valid = 4'b0011;
        load        = 1'b1;
        tick(1);
        load = 1'b0;
        tick(10);
        check("reveal_hex_an", an, 4'hD);
        check("reveal_hex_seg", seg, 7'h78);
        tick(1);
        check("reveal_end_seg", seg, 7'h3F);
        tick(1);
        digit_valid = 4'b0001;
        load        = 1'b1;
        tick(1);
        digit_valid = 4'b0011;
        tick(1);
        digit_valid = 4'b0001;
        tick(1);
        load = 1'b0;
        check("rev_cancel", dut.rev_cnt, 0);
        tick(3);
`else
        rst_n = 1'b1;
        tick(1);
        check("rerelease_anode", an, 4'hE);
        tick(3);
        check("rerelease_next", an, 4'hE);
        tick(1);
        check("rerelease_step", an, 4'hD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pass_display_scanner.md
Name: pass_display_scanner

Overview:
- Time-multiplexed 7-segment driver for the password entry path.
- Parametrised successor to the static per-nibble password decode.
  - Captures a DIGITS-nibble password plus a per-digit "entered" mask on a load strobe.
  - Scans one common anode at a time and drives the shared, registered segment bus.
- Supports blanking of unentered digits and a masked (dash) display mode.
- Sits between the keypad/password FSM and the board display pins.

Parameters:
- DIGITS, 4: number of displayed digits, legal range 1..8.
- SCAN_DIV, 100000: clk cycles each digit is held active; minimum 2.
- REVEAL_CYCLES, 50000000: clear-display hold time for the newest digit; used only with PASS_REVEAL_LAST_EN; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- password_in  in  4*DIGITS  nibble i = bits [4i+3:4i]; digit 0 is rightmost.
- digit_valid  in  DIGITS  bit i set = digit i has been entered.
- load  in  1  single-cycle strobe; captures password_in and digit_valid.
- mask_en  in  1  live (not captured); 1 = show entered digits as dash.
- an  out  DIGITS  anode enables, active-low, one-hot-zero.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1.

Behaviour:
- Reset (async assert, sync-free deassert):
  - pw_q=0, val_q=0, div_cnt=0, idx=0.
  - an=all ones, seg=7'h7F, dp=1.
  - Asserting reset mid-scan blanks the display immediately.
- Capture:
  - load=1 at edge k: pw_q<=password_in, val_q<=digit_valid.
  - The outputs for the currently selected digit reflect the new data at edge k+1.
- Scan counter:
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt==SCAN_DIV-1: div_cnt<=0, and idx<=(idx==DIGITS-1)?0:idx+1. This gives explicit wrap, so non-power-of-2 DIGITS is legal.
- Output register (updated every cycle, one cycle latency from idx/data):
  - an <= ~(1<<idx).
  - seg <= BLANK if !val_q[idx].
  - else seg <= DASH (7'h3F, g only lit) if mask_en.
  - else seg <= hex7(pw_q nibble idx), covering 0-F.
- First active anode: an[0], driven at the first edge after reset release.
- Each digit is active for exactly SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.
- load coincident with an idx change: the new idx and the new data are both used at the next edge.
- mask_en changes take effect on the next edge for the selected digit.
- DIGITS=1: an stays 0 after reset and idx never changes.

Optional Feature:
- Macro: PASS_REVEAL_LAST_EN.
- With the macro defined:
  - On load, if digit_valid has bits set that are not set in val_q, the highest such index is latched as rev_idx and rev_cnt<=REVEAL_CYCLES.
  - While rev_cnt!=0, digit rev_idx displays its hex value even when mask_en=1. rev_cnt decrements each cycle.
  - A new qualifying load restarts the timer on the new index.
  - A load that clears digit_valid[rev_idx] cancels the reveal (rev_cnt<=0).
  - Reset clears rev_cnt and rev_idx.
- Without the macro: no timer logic; mask_en applies uniformly.

Decomposition:
- Package pass_disp_pkg holds:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - The 16-entry hex-to-segment constant table.
  - The macro-independent localparam for counter width, $clog2(SCAN_DIV).
- Sub-module hex_to_seg7: combinational nibble to active-low 7-segment code. It is instantiated once on the muxed nibble, not once per digit.

Test Plan:
- Reset and scan (DIGITS=4, SCAN_DIV=4):
  - During reset: an=4'hF, seg=7'h7F.
  - After release, an steps E,D,B,7,E... every 4 cycles.
- Hex display: load password_in=16'h1A3F, digit_valid=4'hF, mask_en=0 → segs per digit:
  - digit0 'F' = 7'h0E.
  - digit1 '3' = 7'h30.
  - digit2 'A' = 7'h08.
  - digit3 '1' = 7'h79.
- Blank/mask:
  - digit_valid=4'b0011, mask_en=1 → digits 0,1 show 7'h3F; digits 2,3 show 7'h7F.
  - Toggling mask_en=0 shows hex on the next edge.
- Boundary:
  - DIGITS=3, SCAN_DIV=2: an cycles 6,5,3,6 with no illegal index.
  - load coincident with a wrap edge displays the new data.
  - Reset asserted mid-frame forces an=all ones asynchronously.
- Reveal (macro on, REVEAL_CYCLES=10, mask_en=1):
  - digit_valid goes 0001→0011: digit1 shows hex for 10 cycles, then dash.
  - A load with digit_valid=0001 inside the window cancels the reveal.
